// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle RISC-V core.
// It takes a byte stream over valid/ready, assembles little-endian 32-bit
// words and writes them into the instruction memory. The core is kept in
// reset until the whole image has been accepted.
//
// Stream: CNT_LO, CNT_HI (word count N), 4*N data bytes, and one XOR
// checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// Build option: `define IMEM_LOADER_CHECKSUM_EN adds the CSUM state and the
// running XOR. Without it, the last data byte (or an N=0 header) goes
// straight to RUN.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   rx_data/valid     input byte stream
//   rx_ready          loader can accept a byte (registered, state only)
//   im_we/addr/wdata  instruction memory write port (registered, 1-cycle we)
//   core_reset        high while loading or in error
//   load_done         image loaded, core released (sticky)
//   load_err          bad image (sticky)
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_e;

  // State reached once the data phase (or an empty image) is complete.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER = S_CSUM;
`else
  localparam state_e S_AFTER = S_RUN;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        lane_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [31:0]       word_q;
  logic              rx_ready_q, im_we_q, core_reset_q, load_done_q, load_err_q;
  logic [31:0]       im_addr_q, im_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic             acc;
  logic [CNT_W-1:0] n_hdr;
  logic             last_word;

  assign acc       = rx_valid && rx_ready_q;
  assign n_hdr     = CNT_W'({rx_data, cnt_q[7:0]});
  // word_idx_q is the index of the word being assembled; N >= 1 here.
  assign last_word = (CNT_W'(word_idx_q) == (cnt_q - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CNT_LO: if (acc) state_d = S_CNT_HI;
      S_CNT_HI: if (acc) begin
        if (n_hdr > CNT_W'(DEPTH_WORDS)) state_d = S_ERR;
        else if (n_hdr == '0)            state_d = S_AFTER;
        else                             state_d = S_DATA;
      end
      S_DATA: if (acc && lane_q == 2'd3 && last_word) state_d = S_AFTER;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (acc) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CNT_LO;
      cnt_q        <= '0;
      lane_q       <= '0;
      word_idx_q   <= '0;
      word_q       <= '0;
      rx_ready_q   <= 1'b1;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      im_we_q <= 1'b0;
      // Outputs follow the next state so they line up with the transition edge.
      rx_ready_q   <= (state_d != S_RUN) && (state_d != S_ERR);
      core_reset_q <= (state_d != S_RUN);
      load_done_q  <= (state_d == S_RUN);
      load_err_q   <= (state_d == S_ERR);
      if (acc) begin
        case (state_q)
          S_CNT_LO: cnt_q[7:0] <= rx_data;
          S_CNT_HI: cnt_q <= n_hdr;
          S_DATA: begin
            lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ rx_data;
`endif
            if (lane_q == 2'd3) begin
              // Final byte bypasses word_q so the write issues with no stall.
              im_we_q    <= 1'b1;
              im_addr_q  <= 32'({word_idx_q, 2'b00});
              im_wdata_q <= {rx_data, word_q[23:0]};
              word_idx_q <= word_idx_q + IDX_W'(1);
            end else begin
              word_q[{lane_q, 3'b000} +: 8] <= rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every im_we pulse.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, im_we, core_reset, load_done, load_err;
  logic [31:0] im_addr, im_wdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  logic [7:0] xsum;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_reset(core_reset), .load_done(load_done), .load_err(load_err)
  );

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (im_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write got addr=%h data=%h, required no write", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        if (im_addr !== e.addr || im_wdata !== e.data) begin
          n_err++;
          $display("FAIL write got addr=%h data=%h, required addr=%h data=%h",
                   im_addr, im_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %h, required %h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    xsum = 8'h00;
  endtask

  // Offer one byte; it is taken at the first edge where rx_ready is high.
  task automatic send(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    rx_data = b; rx_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout byte=%h not accepted, required accept", b);
    end
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_d(input logic [7:0] b, input bit gap);
    xsum ^= b;
    send(b, gap);
  endtask

  task automatic hdr(input logic [15:0] n, input bit gap);
    send(n[7:0], gap);
    send(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_d(v[8*i +: 8], gap);
  endtask

  task automatic expect_done(input string nm);
    chk({nm, "_done"}, {31'b0, load_done}, 32'd1);
    chk({nm, "_core_rst"}, {31'b0, core_reset}, 32'd0);
    chk({nm, "_rdy"}, {31'b0, rx_ready}, 32'd0);
    chk({nm, "_err"}, {31'b0, load_err}, 32'd0);
  endtask

  task automatic expect_err(input string nm);
    chk({nm, "_err"}, {31'b0, load_err}, 32'd1);
    chk({nm, "_core_rst"}, {31'b0, core_reset}, 32'd1);
    chk({nm, "_rdy"}, {31'b0, rx_ready}, 32'd0);
    chk({nm, "_done"}, {31'b0, load_done}, 32'd0);
  endtask

  // Two-word image; last byte (data or checksum) sent separately for a tight check.
  task automatic two_word(input bit gap, input string nm);
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h00A0_0113});
    hdr(16'd2, gap);
    send_word(32'h0050_0093, gap);
    send_d(8'h13, gap); send_d(8'h01, gap); send_d(8'hA0, gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_d(8'h00, gap);
    chk({nm, "_pre_done"}, {31'b0, load_done}, 32'd0);
    send(xsum, gap);
`else
    chk({nm, "_pre_done"}, {31'b0, load_done}, 32'd0);
    chk({nm, "_pre_core_rst"}, {31'b0, core_reset}, 32'd1);
    send_d(8'h00, gap);
`endif
    expect_done(nm);
  endtask

  initial begin
    do_reset();
    chk("rst_rdy", {31'b0, rx_ready}, 32'd1);
    chk("rst_we", {31'b0, im_we}, 32'd0);
    chk("rst_addr", im_addr, 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_core_rst", {31'b0, core_reset}, 32'd1);
    chk("rst_done", {31'b0, load_done}, 32'd0);
    chk("rst_err", {31'b0, load_err}, 32'd0);

    // Back-to-back bytes, then verify RUN ignores further bytes.
    two_word(1'b0, "n2");
    rx_data = 8'h5A; rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;
    chk("run_ignore_rdy", {31'b0, rx_ready}, 32'd1 ^ 32'd1);
    chk("run_sticky", {31'b0, load_done}, 32'd1);

    // rx_valid toggled every other cycle.
    do_reset();
    two_word(1'b1, "n2gap");

    // Oversized header.
    do_reset();
    hdr(16'd65, 1'b0);
    expect_err("n65");
    rx_data = 8'h11; rx_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 rx_valid = 1'b0;
    chk("n65_sticky", {31'b0, load_err}, 32'd1);

    // Empty image.
    do_reset();
    hdr(16'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("n0_pre_done", {31'b0, load_done}, 32'd0);
    send(8'h00, 1'b0);
    expect_done("n0");
    do_reset();
    hdr(16'd0, 1'b0);
    send(8'h01, 1'b0);
    expect_err("n0bad");
`else
    expect_done("n0");
`endif

    // Single word, checksum 0x44 good / 0x45 bad.
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    hdr(16'd1, 1'b0);
    send_word(32'h4433_2211, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h44, 1'b0);
    expect_done("n1");
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    hdr(16'd1, 1'b0);
    send_word(32'h4433_2211, 1'b0);
    send(8'h45, 1'b0);
    expect_err("n1bad");
`else
    expect_done("n1");
`endif

    // Reset after 6 of 8 data bytes, then a fresh one-word image.
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    hdr(16'd2, 1'b0);
    send_word(32'h0050_0093, 1'b0);
    send_d(8'h13, 1'b0); send_d(8'h01, 1'b0);
    do_reset();
    chk("midrst_done", {31'b0, load_done}, 32'd0);
    chk("midrst_rdy", {31'b0, rx_ready}, 32'd1);
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    hdr(16'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h22, 1'b0);
`endif
    expect_done("midrst");

    // Full-capacity image: N == DEPTH_WORDS is legal, last address 0xFC.
    do_reset();
    hdr(16'd64, 1'b0);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({32'(4 * i), 32'hA500_0000 | 32'(i)});
      send_word(32'hA500_0000 | 32'(i), 1'b0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(xsum, 1'b0);
`endif
    expect_done("n64");

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
